// File: rtl/nic_pkg.sv
// Shared definitions for the CPU network interface: register map,
// status bit position and the per-channel buffer state encoding.
package nic_pkg;

  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

  // Data words are numbered MSB-first, so the status flag lands in the LSB.
  function automatic int nic_stat_bit(input int width);
    return width - 1;
  endfunction

  typedef enum logic {
    CHAN_EMPTY = 1'b0,
    CHAN_FULL  = 1'b1
  } chan_state_t;

endpackage

// File: rtl/nic_chan_buf.sv
// One-entry flit buffer with a full flag; loads are taken only when empty,
// unloads only when full, so both strobes may be raised without pre-gating.
module nic_chan_buf
  import nic_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             unload,
  input  logic [0:WIDTH-1] load_data,
  output logic             full,
  output logic [0:WIDTH-1] data
);

  chan_state_t state, state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CHAN_EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CHAN_EMPTY: if (load)   state_next = CHAN_FULL;
      CHAN_FULL:  if (unload) state_next = CHAN_EMPTY;
      default:    state_next = CHAN_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             data <= '0;
    else if (load && state == CHAN_EMPTY)  data <= load_data;
  end

  assign full = (state == CHAN_FULL);

endmodule

// File: rtl/cpu_nic.sv
// Memory-mapped bridge between the CPU data port and one router local port:
// an input flit register, an output flit register and their status words.
module cpu_nic
  import nic_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di
);

  localparam int STAT_BIT = nic_stat_bit(DATA_WIDTH);

  logic                  rd_req, wr_req;
  logic                  in_full, out_full;
  logic [0:DATA_WIDTH-1] in_buf, out_buf;
  logic [0:DATA_WIDTH-1] d_out_next;

  assign rd_req = nicEn & ~nicWrEn;
  assign wr_req = nicEn & nicWrEn;

  nic_chan_buf #(.WIDTH(DATA_WIDTH)) u_in_chan (
    .clk       (clk),
    .reset     (reset),
    .load      (net_si),
    .unload    (rd_req && addr == NIC_IN_BUF),
    .load_data (net_di),
    .full      (in_full),
    .data      (in_buf)
  );

  nic_chan_buf #(.WIDTH(DATA_WIDTH)) u_out_chan (
    .clk       (clk),
    .reset     (reset),
    .load      (wr_req && addr == NIC_OUT_BUF),
    .unload    (net_ro),
    .load_data (d_in),
    .full      (out_full),
    .data      (out_buf)
  );

  assign net_ri = ~in_full;
  assign net_so = out_full;
  assign net_do = out_buf;

  // Status reads report the flag as seen before the edge of the access.
  always_comb begin
    d_out_next = d_out;
    if (rd_req) begin
      d_out_next = '0;
      case (addr)
        NIC_IN_BUF:   d_out_next = in_buf;
        NIC_IN_STAT:  d_out_next[STAT_BIT] = in_full;
        NIC_OUT_BUF:  d_out_next = out_buf;
        NIC_OUT_STAT: d_out_next[STAT_BIT] = out_full;
        default:      d_out_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_out <= '0;
    else       d_out <= d_out_next;
  end

endmodule

// File: tb/tb_cpu_nic.sv
// Directed bench for cpu_nic: a register-level model of the two channels is
// compared every cycle, plus literal checks of the documented scenarios.
module tb_cpu_nic;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'b00;
  logic [0:63] d_in = '0;
  logic [0:63] d_out;
  logic        nicEn = 1'b0;
  logic        nicWrEn = 1'b0;
  logic        net_so;
  logic        net_ro = 1'b0;
  logic [0:63] net_do;
  logic        net_si = 1'b0;
  logic        net_ri;
  logic [0:63] net_di = '0;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_in_buf = '0, m_out_buf = '0, m_d_out = '0;
  logic        m_in_full = 1'b0, m_out_full = 1'b0;

  cpu_nic #(.DATA_WIDTH(64)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .d_in    (d_in),
    .d_out   (d_out),
    .nicEn   (nicEn),
    .nicWrEn (nicWrEn),
    .net_so  (net_so),
    .net_ro  (net_ro),
    .net_do  (net_do),
    .net_si  (net_si),
    .net_ri  (net_ri),
    .net_di  (net_di)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge.
  task automatic applyStimulus(input logic en, input logic wr, input logic [1:0] a,
                               input logic [63:0] din, input logic si,
                               input logic [63:0] di, input logic ro);
    @(negedge clk);
    nicEn = en; nicWrEn = wr; addr = a; d_in = din;
    net_si = si; net_di = di; net_ro = ro;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic cpuRead(input logic [1:0] a);
    applyStimulus(1'b1, 1'b0, a, 64'h0, 1'b0, 64'h0, 1'b0);
  endtask

  // Register-level model: every decision uses the state from before the edge.
  always @(posedge clk or posedge reset) begin
    logic pin, pout;
    if (reset) begin
      m_in_buf = '0; m_out_buf = '0; m_d_out = '0;
      m_in_full = 1'b0; m_out_full = 1'b0;
    end else begin
      pin = m_in_full;
      pout = m_out_full;
      if (nicEn && !nicWrEn) begin
        case (addr)
          2'b00: m_d_out = m_in_buf;
          2'b01: m_d_out = {63'h0, pin};
          2'b10: m_d_out = m_out_buf;
          default: m_d_out = {63'h0, pout};
        endcase
        if (addr == 2'b00 && pin) m_in_full = 1'b0;
      end
      if (net_si && !pin) begin
        m_in_buf = net_di;
        m_in_full = 1'b1;
      end
      if (nicEn && nicWrEn && addr == 2'b10 && !pout) begin
        m_out_buf = d_in;
        m_out_full = 1'b1;
      end
      if (pout && net_ro) m_out_full = 1'b0;
    end
    #1;
    checkOutput("d_out", d_out, m_d_out);
    checkOutput("net_so", {63'h0, net_so}, {63'h0, m_out_full});
    checkOutput("net_ri", {63'h0, net_ri}, {63'h0, !m_in_full});
    checkOutput("net_do", net_do, m_out_buf);
  end

  initial begin
    $display("[TB] cpu_nic bench start");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Fill both channels, load d_out, then reset between edges.
    applyStimulus(1'b1, 1'b1, 2'b10, 64'h1111, 1'b1, 64'h2222, 1'b0);
    cpuRead(2'b10);
    idle();
    checkOutput("pre_reset_dout", d_out, 64'h1111);
    checkOutput("pre_reset_so", {63'h0, net_so}, 64'h1);
    checkOutput("pre_reset_ri", {63'h0, net_ri}, 64'h0);
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_so", {63'h0, net_so}, 64'h0);
    checkOutput("reset_ri", {63'h0, net_ri}, 64'h1);
    checkOutput("reset_dout", d_out, 64'h0);
    checkOutput("reset_do", net_do, 64'h0);
    #4 reset = 1'b0;
    cpuRead(2'b01);
    cpuRead(2'b11);
    checkOutput("reset_in_stat", d_out, 64'h0);
    idle();
    checkOutput("reset_out_stat", d_out, 64'h0);

    // Output flit held while the router stalls, duplicate write dropped.
    applyStimulus(1'b1, 1'b1, 2'b10, 64'hDEAD_BEEF_0123_4567, 1'b0, 64'h0, 1'b0);
    repeat (3) idle();
    checkOutput("out_hold_so", {63'h0, net_so}, 64'h1);
    checkOutput("out_hold_do", net_do, 64'hDEAD_BEEF_0123_4567);
    applyStimulus(1'b1, 1'b1, 2'b10, 64'h1, 1'b0, 64'h0, 1'b0);
    idle();
    checkOutput("out_drop_do", net_do, 64'hDEAD_BEEF_0123_4567);
    applyStimulus(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b1);
    cpuRead(2'b11);
    checkOutput("out_sent_so", {63'h0, net_so}, 64'h0);
    idle();
    checkOutput("out_sent_stat", d_out, 64'h0);

    // Input flit receive, status poll and consume.
    applyStimulus(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
    idle();
    checkOutput("in_ri_fall", {63'h0, net_ri}, 64'h0);
    cpuRead(2'b01);
    idle();
    checkOutput("in_stat_full", d_out, 64'h1);
    cpuRead(2'b00);
    idle();
    checkOutput("in_read_data", d_out, 64'hA5A5_A5A5_A5A5_A5A5);
    cpuRead(2'b01);
    idle();
    checkOutput("in_stat_empty", d_out, 64'h0);

    // Consume and new arrival in the same cycle: one-cycle bubble.
    applyStimulus(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 64'h3, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 64'h0, 1'b1, 64'h7, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 64'h7, 1'b0);
    checkOutput("bubble_dout", d_out, 64'h3);
    checkOutput("bubble_ri", {63'h0, net_ri}, 64'h1);
    idle();
    checkOutput("bubble_accept_ri", {63'h0, net_ri}, 64'h0);
    cpuRead(2'b00);
    idle();
    checkOutput("bubble_data", d_out, 64'h7);

    // Send and receive in the same cycle, then a stale read of the empty input.
    applyStimulus(1'b1, 1'b1, 2'b10, 64'hCAFE, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 64'hBEEF, 1'b1);
    idle();
    checkOutput("dual_so", {63'h0, net_so}, 64'h0);
    checkOutput("dual_ri", {63'h0, net_ri}, 64'h0);
    cpuRead(2'b01);
    cpuRead(2'b11);
    checkOutput("dual_in_stat", d_out, 64'h1);
    cpuRead(2'b00);
    checkOutput("dual_out_stat", d_out, 64'h0);
    cpuRead(2'b00);
    checkOutput("dual_in_data", d_out, 64'hBEEF);
    idle();
    checkOutput("stale_in_data", d_out, 64'hBEEF);
    checkOutput("stale_ri", {63'h0, net_ri}, 64'h1);

    // Writes to non-output registers are ignored.
    applyStimulus(1'b1, 1'b1, 2'b00, 64'h55, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b11, 64'h55, 1'b0, 64'h0, 1'b0);
    idle();
    checkOutput("ignored_wr_so", {63'h0, net_so}, 64'h0);
    checkOutput("ignored_wr_dout", d_out, 64'hBEEF);

    repeat (2) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_nic.md
# cpu_nic

Memory-mapped network interface that answers the processor's data-memory port (`addr`/`d_in`/`nicEn`/`nicWrEn` in, `d_out` back) and bridges it to one ring router's local port. It holds one input-channel flit (router to CPU) and one output-channel flit (CPU to router), each with a full/empty status register the CPU polls by ordinary loads. It is instantiated beside the data memory; the top level steers the CPU's memory request here by address decode.

## Interface
- `DATA_WIDTH`, 64, flit and CPU data width (bit 0 is MSB)
- `clk` input 1 — system clock, rising edge
- `reset` input 1 — asynchronous, active-high
- `addr` input 2 — register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status
- `d_in` input DATA_WIDTH — CPU write data
- `d_out` output DATA_WIDTH — CPU read data, registered
- `nicEn` input 1 — access request this cycle
- `nicWrEn` input 1 — 1 write, 0 read (qualified by `nicEn`)
- `net_so` output 1 — output flit valid toward router
- `net_ro` input 1 — router can accept output flit
- `net_do` output DATA_WIDTH — output flit
- `net_si` input 1 — router presents input flit
- `net_ri` output 1 — NIC can accept input flit
- `net_di` input DATA_WIDTH — input flit

## Operation
- State: `in_buf`, `in_full`, `out_buf`, `out_full`; each channel is a two-state machine EMPTY/FULL.
- Input channel: `net_ri = ~in_full`. `net_si & net_ri` at an edge: `in_buf <= net_di`, EMPTY->FULL. CPU read of 00 while FULL: `d_out <= in_buf`, FULL->EMPTY. Read of 00 while EMPTY: `d_out <= in_buf` (stale), no state change.
- Output channel: `net_so = out_full`, `net_do = out_buf`. CPU write to 10 while EMPTY: `out_buf <= d_in`, EMPTY->FULL. Write to 10 while FULL: dropped, no change. `net_so & net_ro` at an edge: FULL->EMPTY.
- Status reads (01, 11): `d_out` = 0 except bit DATA_WIDTH-1 = `in_full` / `out_full` (value before the edge).
- Writes to 00, 01, 11: ignored. Reads of 10: `d_out <= out_buf`, no state change.
- No access (`nicEn=0`): `d_out` holds its value.

## Timing
- Reset: `d_out`=0, `in_buf`=0, `out_buf`=0, `in_full`=0, `out_full`=0, so `net_ri`=1, `net_so`=0, `net_do`=0. Reset mid-transfer discards both buffers.
- Read latency: 1 cycle; `d_out` valid the cycle after `nicEn & ~nicWrEn`.
- Write takes effect at the request edge; `net_so` rises the following cycle.
- All full/empty decisions use pre-edge state: CPU consume of 00 and `net_si` in the same cycle — `net_ri`=0, no accept; next flit accepted one cycle later (one-cycle bubble, required).
- Output-buffer write in the same cycle as its network send: buffer was FULL, write dropped; CPU must poll 11 first.
- Both channels may transfer in the same cycle independently.
- `net_do`/`net_so` driven directly from registers, no combinational path from `net_ro`.

## Structure
- Package `nic_pkg`: address constants `NIC_IN_BUF=2'b00`, `NIC_IN_STAT=2'b01`, `NIC_OUT_BUF=2'b10`, `NIC_OUT_STAT=2'b11`; status bit index.
- One sub-module `nic_chan_buf`: one-entry buffer with load/unload strobes and full flag; instantiated twice (input, output).
- Top handles address decode, `d_out` mux/register, handshake wiring.

## Test plan
- Reset asserted mid-cycle with both buffers full -> immediately `net_so`=0, `net_ri`=1, `d_out`=0; read 01 and 11 return 0.
- Write 64'hDEAD_BEEF_0123_4567 to 10, `net_ro`=0 for 3 cycles -> `net_so`=1 holding data; `net_ro`=1 -> one-cycle transfer, then read 11 returns 0.
- Second write 64'h1 to 10 while full -> dropped; `net_do` still 64'hDEAD_BEEF_0123_4567.
- `net_si`=1, `net_di`=64'hA5A5… -> `net_ri` falls next cycle; read 01 returns 64'h1; read 00 returns 64'hA5A5… one cycle later; subsequent 01 read returns 0.
- Read 00 and `net_si`=1 (new 64'h7) in same cycle -> flit not accepted that cycle, accepted next cycle; later read 00 returns 64'h7.
- Simultaneous output send and input accept in one cycle -> both complete, both status flags correct.
